weight_stream_unpacker: RTL and testbench

- Downstream consumer of the SPRAM-backed flash loader FIFO.
- Pops 32-bit words from the loader and re-serialises them into an 8-bit valid/ready byte stream in flash byte order, for the CNN weight/parameter consumer.
- Bounds each pass to a fixed word count, accumulates a 16-bit byte checksum, and controls the loader read pointer through o_fill so weights can be replayed every inference.

---
 rtl/weight_stream_unpacker_if.sv | 19 +
 rtl/weight_stream_unpacker.sv | 141 ++++++++++++++
 tb/tb_weight_stream_unpacker.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_stream_unpacker_if.sv
// Byte stream from the weight unpacker to the CNN weight/parameter consumer.
// The master offers a byte with valid. The slave takes it by raising ready.
interface weight_stream_unpacker_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );
endinterface

// File: rtl/weight_stream_unpacker.sv
// Weight stream unpacker.
// Pops 32-bit words from the SPRAM flash loader FIFO and sends them out one
// byte at a time, in flash byte order. Each pass is limited to TOTAL_WORDS
// words. A 16-bit byte checksum is accumulated over the pass. Dropping o_fill
// rewinds the loader, so the weights can be replayed for every inference.
module weight_stream_unpacker #(
  parameter int TOTAL_WORDS = 24576,
  parameter int CNT_W       = 15
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic                     i_load_done,
  output logic                     o_fill,
  input  logic                     i_fifo_empty,
  output logic                     o_fifo_rd,
  input  logic [31:0]              i_fifo_dout,
  weight_stream_unpacker_if.master byte_if,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [15:0]              o_checksum
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [31:0]      word_reg;
  logic [1:0]       byte_idx;
  logic             word_full;
  logic [CNT_W-1:0] word_cnt;
  logic             rd_q;
  logic [7:0]       byte_sel;
  logic             kill;
  logic             hs;
  logic             last_hs;
  logic             pop;

  // An abort, or the loader losing its data mid-pass, discards the whole pass.
  assign kill    = i_abort || ((state == RUN) && !i_load_done);
  assign hs      = word_full && byte_if.byte_ready;
  assign last_hs = hs && (byte_idx == 2'd3);

  // Pop only after the previous pop has had one cycle to update the empty
  // flag. Pop only when the register is free or is sending its last byte, so
  // the next word follows that byte without a gap.
  assign pop = (state == RUN) && !kill && !i_fifo_empty && (!word_full || last_hs)
               && !rd_q && (word_cnt < LAST_CNT);

  assign o_fifo_rd          = pop;
  assign byte_if.byte_valid = word_full;
  assign byte_if.byte_data  = byte_sel;

  // Select the current byte, low byte first (flash byte order).
  always_comb begin
    byte_sel = word_reg[7:0];
    case (byte_idx)
      2'd0:    byte_sel = word_reg[7:0];
      2'd1:    byte_sel = word_reg[15:8];
      2'd2:    byte_sel = word_reg[23:16];
      default: byte_sel = word_reg[31:24];
    endcase
  end

  // Pass control FSM together with the word register, word counter and checksum.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      o_fill     <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_checksum <= 16'h0000;
      word_reg   <= 32'h0000_0000;
      byte_idx   <= 2'd0;
      word_full  <= 1'b0;
      word_cnt   <= '0;
      rd_q       <= 1'b0;
    end else if (kill) begin
      state      <= IDLE;
      o_fill     <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_checksum <= 16'h0000;
      word_reg   <= 32'h0000_0000;
      byte_idx   <= 2'd0;
      word_full  <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      rd_q <= pop;
      if (pop) begin
        word_reg  <= i_fifo_dout;
        byte_idx  <= 2'd0;
        word_full <= 1'b1;
        word_cnt  <= word_cnt + CNT_W'(1);
      end else if (hs) begin
        if (byte_idx == 2'd3) begin
          word_full <= 1'b0;
        end else begin
          byte_idx <= byte_idx + 2'd1;
        end
      end
      if (hs) begin
        o_checksum <= o_checksum + {8'h00, byte_sel};
      end
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            state      <= FILL;
            o_fill     <= 1'b1;
            o_busy     <= 1'b1;
            o_done     <= 1'b0;
            o_checksum <= 16'h0000;
            word_cnt   <= '0;
          end
        end
        FILL: begin
          if (i_load_done) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (last_hs && (word_cnt == LAST_CNT)) begin
            state  <= DONE;
            o_fill <= 1'b0;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_stream_unpacker.sv
// Testbench for weight_stream_unpacker.
// The main DUT runs short passes of 4 words against a show-ahead FIFO model.
// A second DUT runs a 300-word all-0xFF pass, which makes the checksum wrap.
module tb_weight_stream_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        i_start;
  logic        i_abort;
  logic        i_load_done;
  logic        o_fill;
  logic        fifo_empty = 1'b1;
  logic        o_fifo_rd;
  logic [31:0] fifo_dout;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_checksum;
  logic        force_empty;
  logic [5:0]  rptr = 6'd0;
  logic [7:0]  base;

  logic        start2;
  logic        fill2;
  logic        rd2;
  logic        busy2;
  logic        done2;
  logic [15:0] cks2;

  weight_stream_unpacker_if bif ();
  weight_stream_unpacker_if bif2 ();

  weight_stream_unpacker #(.TOTAL_WORDS(4), .CNT_W(3)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_load_done  (i_load_done),
    .o_fill       (o_fill),
    .i_fifo_empty (fifo_empty),
    .o_fifo_rd    (o_fifo_rd),
    .i_fifo_dout  (fifo_dout),
    .byte_if      (bif),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_checksum   (o_checksum)
  );

  weight_stream_unpacker #(.TOTAL_WORDS(300), .CNT_W(9)) dut2 (
    .clk          (clk),
    .resetn       (resetn),
    .i_start      (start2),
    .i_abort      (1'b0),
    .i_load_done  (1'b1),
    .o_fill       (fill2),
    .i_fifo_empty (1'b0),
    .o_fifo_rd    (rd2),
    .i_fifo_dout  (32'hFFFF_FFFF),
    .byte_if      (bif2),
    .o_busy       (busy2),
    .o_done       (done2),
    .o_checksum   (cks2)
  );

  // Loader FIFO model: word n holds bytes 4n..4n+3. The empty flag lags the
  // forced value by one cycle. A low o_fill rewinds the read pointer.
  assign base      = {rptr, 2'b00};
  assign fifo_dout = {base + 8'd3, base + 8'd2, base + 8'd1, base};

  always @(posedge clk) begin
    fifo_empty <= force_empty;
    if (!o_fill) rptr <= 6'd0;
    else if (o_fifo_rd) rptr <= rptr + 6'd1;
  end

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         bytes_seen;
  int         pops_seen;
  logic [7:0] first_byte;
  logic       prev_rd;
  logic       prev_valid;
  logic       prev_ready;
  logic       prev_kill;
  logic [7:0] prev_data;
  bit         toggle_ready;
  int         bytes2;
  int         pops2;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One clock: monitor and score at the falling edge, then advance past the
  // rising edge.
  task automatic stepCycle();
    @(negedge clk);
    if (o_fifo_rd) begin
      checkOutput("rd_while_empty", 32'(fifo_empty), 32'd0);
      checkOutput("rd_back_to_back", 32'(prev_rd), 32'd0);
      exp_q.push_back(fifo_dout[7:0]);
      exp_q.push_back(fifo_dout[15:8]);
      exp_q.push_back(fifo_dout[23:16]);
      exp_q.push_back(fifo_dout[31:24]);
      pops_seen++;
    end
    if (prev_valid && !prev_ready && !prev_kill) begin
      checkOutput("stall_valid", 32'(bif.byte_valid), 32'd1);
      checkOutput("stall_data", 32'(bif.byte_data), 32'(prev_data));
    end
    if (bif.byte_valid && bif.byte_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_depth", 32'(exp_q.size()), 32'd1);
      end else begin
        if (bytes_seen == 0) first_byte = bif.byte_data;
        checkOutput("byte_data", 32'(bif.byte_data), 32'(exp_q.pop_front()));
      end
      bytes_seen++;
    end
    prev_rd    = o_fifo_rd;
    prev_valid = bif.byte_valid;
    prev_ready = bif.byte_ready;
    prev_data  = bif.byte_data;
    prev_kill  = i_abort || !i_load_done;
    if (rd2) pops2++;
    if (bif2.byte_valid) begin
      bytes2++;
      checkOutput("full_byte", 32'(bif2.byte_data), 32'hFF);
    end
    @(posedge clk);
    #1;
    if (toggle_ready) bif.byte_ready = ~bif.byte_ready;
  endtask

  task automatic applyStimulus(input logic start, input logic abort);
    i_start = start;
    i_abort = abort;
    stepCycle();
    i_start = 1'b0;
    i_abort = 1'b0;
  endtask

  task automatic clearStats();
    exp_q.delete();
    bytes_seen = 0;
    pops_seen  = 0;
    first_byte = 8'hEE;
  endtask

  task automatic waitDone(input int max_cycles, input string tag);
    int n = 0;
    while (!o_done && n < max_cycles) begin
      stepCycle();
      n++;
    end
    checkOutput({tag, "_done_seen"}, 32'(o_done), 32'd1);
  endtask

  task automatic waitBytes(input int target, input int max_cycles, input string tag);
    int n = 0;
    while (bytes_seen < target && n < max_cycles) begin
      stepCycle();
      n++;
    end
    checkOutput({tag, "_bytes_reached"}, 32'(bytes_seen), 32'(target));
  endtask

  task automatic checkFullPass(input string tag);
    checkOutput({tag, "_bytes"}, 32'(bytes_seen), 32'd16);
    checkOutput({tag, "_pops"}, 32'(pops_seen), 32'd4);
    checkOutput({tag, "_checksum"}, 32'(o_checksum), 32'h0078);
    checkOutput({tag, "_first_byte"}, 32'(first_byte), 32'h00);
    checkOutput({tag, "_fill"}, 32'(o_fill), 32'd0);
    checkOutput({tag, "_busy"}, 32'(o_busy), 32'd0);
    checkOutput({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    resetn          = 1'b0;
    i_start         = 1'b0;
    i_abort         = 1'b0;
    i_load_done     = 1'b1;
    force_empty     = 1'b0;
    toggle_ready    = 1'b0;
    bif.byte_ready  = 1'b1;
    bif2.byte_ready = 1'b1;
    start2          = 1'b0;
    prev_rd         = 1'b0;
    prev_valid      = 1'b0;
    prev_ready      = 1'b0;
    prev_kill       = 1'b0;
    prev_data       = 8'h00;
    bytes2          = 0;
    pops2           = 0;
    clearStats();
    repeat (3) stepCycle();

    // Reset state
    checkOutput("rst_fill", 32'(o_fill), 32'd0);
    checkOutput("rst_rd", 32'(o_fifo_rd), 32'd0);
    checkOutput("rst_valid", 32'(bif.byte_valid), 32'd0);
    checkOutput("rst_data", 32'(bif.byte_data), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_done", 32'(o_done), 32'd0);
    checkOutput("rst_checksum", 32'(o_checksum), 32'd0);
    resetn = 1'b1;
    stepCycle();

    // Basic pass: bytes 0x00..0x0F in order
    clearStats();
    applyStimulus(1'b1, 1'b0);
    checkOutput("t1_busy_after_start", 32'(o_busy), 32'd1);
    checkOutput("t1_fill_after_start", 32'(o_fill), 32'd1);
    waitDone(100, "t1");
    checkFullPass("t1");
    repeat (3) stepCycle();
    checkOutput("t1_done_held", 32'(o_done), 32'd1);
    checkOutput("t1_no_extra_pop", 32'(pops_seen), 32'd4);

    // Replay with ready toggling every cycle
    clearStats();
    toggle_ready = 1'b1;
    applyStimulus(1'b1, 1'b0);
    waitDone(200, "t2");
    checkFullPass("t2");
    toggle_ready   = 1'b0;
    bif.byte_ready = 1'b1;

    // FIFO empty for 20 cycles mid-pass; a start during RUN is ignored
    clearStats();
    applyStimulus(1'b1, 1'b0);
    waitBytes(6, 100, "t3");
    force_empty = 1'b1;
    repeat (5) stepCycle();
    applyStimulus(1'b1, 1'b0);
    checkOutput("t3_start_ignored_busy", 32'(o_busy), 32'd1);
    for (int i = 0; i < 14; i++) begin
      stepCycle();
      checkOutput("t3_gap_valid", 32'(bif.byte_valid), 32'd0);
    end
    checkOutput("t3_gap_bytes", 32'(bytes_seen), 32'd8);
    checkOutput("t3_gap_pops", 32'(pops_seen), 32'd2);
    force_empty = 1'b0;
    waitDone(100, "t3");
    checkFullPass("t3");

    // Abort after 5 bytes, then replay from byte 0x00
    clearStats();
    applyStimulus(1'b1, 1'b0);
    waitBytes(5, 100, "t4");
    i_abort = 1'b1;
    #1;
    checkOutput("t4_abort_no_pop", 32'(o_fifo_rd), 32'd0);
    stepCycle();
    i_abort = 1'b0;
    checkOutput("t4_fill", 32'(o_fill), 32'd0);
    checkOutput("t4_valid", 32'(bif.byte_valid), 32'd0);
    checkOutput("t4_busy", 32'(o_busy), 32'd0);
    checkOutput("t4_done", 32'(o_done), 32'd0);
    checkOutput("t4_checksum", 32'(o_checksum), 32'd0);
    clearStats();
    applyStimulus(1'b1, 1'b0);
    waitDone(100, "t4_replay");
    checkFullPass("t4_replay");

    // Loader data lost during RUN, just as a pop is due
    clearStats();
    applyStimulus(1'b1, 1'b0);
    waitBytes(3, 100, "t5");
    i_load_done = 1'b0;
    #1;
    checkOutput("t5_drop_no_pop", 32'(o_fifo_rd), 32'd0);
    stepCycle();
    checkOutput("t5_busy", 32'(o_busy), 32'd0);
    checkOutput("t5_done", 32'(o_done), 32'd0);
    checkOutput("t5_fill", 32'(o_fill), 32'd0);
    checkOutput("t5_valid", 32'(bif.byte_valid), 32'd0);

    // Start while the loader is not ready: stays in FILL with no pops
    clearStats();
    applyStimulus(1'b1, 1'b0);
    repeat (10) stepCycle();
    checkOutput("t5_fill_busy", 32'(o_busy), 32'd1);
    checkOutput("t5_fill_fill", 32'(o_fill), 32'd1);
    checkOutput("t5_fill_pops", 32'(pops_seen), 32'd0);
    checkOutput("t5_fill_valid", 32'(bif.byte_valid), 32'd0);
    i_load_done = 1'b1;
    waitDone(100, "t5_resume");
    checkFullPass("t5_resume");

    // Start and abort together: abort wins
    applyStimulus(1'b1, 1'b1);
    checkOutput("t6_busy", 32'(o_busy), 32'd0);
    checkOutput("t6_done", 32'(o_done), 32'd0);
    checkOutput("t6_fill", 32'(o_fill), 32'd0);

    // Long all-0xFF pass on the second instance: the checksum wraps
    bytes2 = 0;
    pops2  = 0;
    start2 = 1'b1;
    stepCycle();
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 2000) begin
      stepCycle();
      n++;
    end
    checkOutput("t7_done_seen", 32'(done2), 32'd1);
    checkOutput("t7_bytes", 32'(bytes2), 32'd1200);
    checkOutput("t7_pops", 32'(pops2), 32'd300);
    checkOutput("t7_checksum", 32'(cks2), 32'hAB50);
    checkOutput("t7_fill", 32'(fill2), 32'd0);
    checkOutput("t7_busy", 32'(busy2), 32'd0);
    repeat (5) stepCycle();
    checkOutput("t7_no_extra_pop", 32'(pops2), 32'd300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
